// File: rtl/ql_timing_pkg.sv
// ---------------------------------------------------------------------------
// ql_timing_pkg
// Shared definitions for the QL ZX8301 bus-contention model: contention mode
// and FSM state encodings, default timing constants and the slot-grant
// helper used by ql_bus_timing.
// ---------------------------------------------------------------------------
package ql_timing_pkg;

   localparam int DEF_CYC_PER_CHUNK   = 12;
   localparam int DEF_CHUNKS_PER_LINE = 40;
   localparam int DEF_BUSY_ACTIVE     = 32;
   localparam int DEF_BUSY_VBLANK     = 8;
   localparam int DEF_RD_EXTRA        = 4;
   localparam int DEF_WR_EXTRA        = 5;
   localparam int DEF_IO_WAIT         = 3;
   localparam int DEF_STAT_W          = 16;

   // Modes 2 and 3 both disable timing; only bit 1 matters for that test.
   typedef enum logic [1:0] {
      MODE_ORIG   = 2'd0,
      MODE_NOCONT = 2'd1,
      MODE_OFF    = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      FSM_IDLE   = 2'd0,
      FSM_DECIDE = 2'd1,
      FSM_EXTRA  = 2'd2,
      FSM_IOWAIT = 2'd3
   } fsm_state_e;

   function automatic logic mode_is_off(input logic [1:0] m);
      return m[1];
   endfunction

   // ROM accesses never wait for a video slot in the original mode.
   function automatic logic grant_f(input logic [1:0] m, input logic rom,
                                    input logic slot_free);
      logic g;
      case (mode_e'(m))
         MODE_ORIG:   g = rom | slot_free;
         MODE_NOCONT: g = 1'b1;
         default:     g = 1'b0;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/ql_bus_timing_if.sv
// ---------------------------------------------------------------------------
// ql_bus_timing_if
// CPU-side bus signals seen by the contention model.
//   cpu_uds/cpu_lds : data strobes       cpu_rw  : 1 = read
//   cpu_rom         : ROM region         cpu_io  : I/O region
//   ram_delay_dtack : 1 = hold off DTACK (driven by the timing model)
// master = CPU bus decoder side, slave = ql_bus_timing.
// ---------------------------------------------------------------------------
interface ql_bus_timing_if;
   logic cpu_uds;
   logic cpu_lds;
   logic cpu_rw;
   logic cpu_rom;
   logic cpu_io;
   logic ram_delay_dtack;

   modport master (
      output cpu_uds, cpu_lds, cpu_rw, cpu_rom, cpu_io,
      input  ram_delay_dtack
   );

   modport slave (
      input  cpu_uds, cpu_lds, cpu_rw, cpu_rom, cpu_io,
      output ram_delay_dtack
   );
endinterface

// File: rtl/ql_slot_counter.sv
// ---------------------------------------------------------------------------
// ql_slot_counter
// Tracks the position within a display line (tick within chunk, chunk within
// line) and flags whether the CPU may use the current tick.
//   clk_sys, reset : clock, synchronous active-high reset
//   clear          : holds the counters at zero (timing disabled)
//   ce_bus_p       : bus tick enable
//   vblank         : selects the vblank refresh reservation
//   slot_free      : CPU slot available on this tick
// ---------------------------------------------------------------------------
module ql_slot_counter #(
   parameter int CYC_PER_CHUNK   = 12,
   parameter int CHUNKS_PER_LINE = 40,
   parameter int BUSY_ACTIVE     = 32,
   parameter int BUSY_VBLANK     = 8
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic clear,
   input  logic ce_bus_p,
   input  logic vblank,
   output logic slot_free
);

   localparam int CYC_W = (CYC_PER_CHUNK > 1)   ? $clog2(CYC_PER_CHUNK)   : 1;
   localparam int CHK_W = (CHUNKS_PER_LINE > 1) ? $clog2(CHUNKS_PER_LINE) : 1;
   // One extra bit so a reservation equal to the line length still compares correctly.
   localparam int CMP_W = CHK_W + 1;

   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYC_PER_CHUNK - 1);
   localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
   localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
   localparam logic [CHK_W-1:0] CHK_LAST = CHK_W'(CHUNKS_PER_LINE - 1);
   localparam logic [CHK_W-1:0] CHK_ONE  = CHK_W'(1);
   localparam logic [CHK_W-1:0] CHK_ZERO = {CHK_W{1'b0}};
   localparam logic [CMP_W-1:0] BUSY_A   = CMP_W'(BUSY_ACTIVE);
   localparam logic [CMP_W-1:0] BUSY_V   = CMP_W'(BUSY_VBLANK);

   logic [CYC_W-1:0] cyc_r;
   logic [CHK_W-1:0] chunk_r;
   logic [CMP_W-1:0] busy_s;

   // Advance the tick/chunk position once per bus tick
   always_ff @(posedge clk_sys) begin
      if (reset || clear) begin
         cyc_r   <= CYC_ZERO;
         chunk_r <= CHK_ZERO;
      end else if (ce_bus_p) begin
         if (cyc_r == CYC_LAST) begin
            cyc_r   <= CYC_ZERO;
            chunk_r <= (chunk_r == CHK_LAST) ? CHK_ZERO : (chunk_r + CHK_ONE);
         end else begin
            cyc_r <= cyc_r + CYC_ONE;
         end
      end
   end

   // Tick 0 of every chunk is always left to the CPU, even in fetch chunks
   always_comb begin
      busy_s    = vblank ? BUSY_V : BUSY_A;
      slot_free = ({1'b0, chunk_r} >= busy_s) || (cyc_r == CYC_ZERO);
   end

endmodule

// File: rtl/ql_bus_timing.sv
// ---------------------------------------------------------------------------
// ql_bus_timing
// Cycle-level ZX8301 contention model. Holds off DTACK so CPU accesses take
// roughly as long as on the original 8-bit bus, including video-fetch slots,
// vblank refresh slots, the second byte of 16-bit accesses and I/O waits.
//   clk_sys, reset   : clock, synchronous active-high reset
//   enable           : 0 = timing state held cleared
//   ce_bus_p         : bus tick enable
//   vblank           : selects vblank vs active slot reservation
//   mode             : 0 original, 1 no slot contention, 2/3 timing off
//   bus (slave)      : CPU strobes/region in, ram_delay_dtack out
//   stall_ticks      : saturating count of ticks with DTACK held off
// ---------------------------------------------------------------------------
module ql_bus_timing
   import ql_timing_pkg::*;
#(
   parameter int CYC_PER_CHUNK   = DEF_CYC_PER_CHUNK,
   parameter int CHUNKS_PER_LINE = DEF_CHUNKS_PER_LINE,
   parameter int BUSY_ACTIVE     = DEF_BUSY_ACTIVE,
   parameter int BUSY_VBLANK     = DEF_BUSY_VBLANK,
   parameter int RD_EXTRA        = DEF_RD_EXTRA,
   parameter int WR_EXTRA        = DEF_WR_EXTRA,
   parameter int IO_WAIT         = DEF_IO_WAIT,
   parameter int STAT_W          = DEF_STAT_W
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              enable,
   input  logic              ce_bus_p,
   input  logic              vblank,
   input  logic [1:0]        mode,
   ql_bus_timing_if.slave    bus,
   output logic [STAT_W-1:0] stall_ticks
);

   localparam logic [1:0] ST_IDLE   = FSM_IDLE;
   localparam logic [1:0] ST_DECIDE = FSM_DECIDE;
   localparam logic [1:0] ST_EXTRA  = FSM_EXTRA;
   localparam logic [1:0] ST_IOWAIT = FSM_IOWAIT;

   localparam int RW_MAX  = (RD_EXTRA > WR_EXTRA) ? RD_EXTRA : WR_EXTRA;
   localparam int CNT_MAX = (RW_MAX > IO_WAIT) ? RW_MAX : IO_WAIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_RD   = CNT_W'(RD_EXTRA);
   localparam logic [CNT_W-1:0]  CNT_WR   = CNT_W'(WR_EXTRA);
   localparam logic [CNT_W-1:0]  CNT_IO   = CNT_W'(IO_WAIT);
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
   localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

   logic              slot_free_s;
   logic              grant_s;
   logic              mode_off_s;
   logic              ds_s;
   logic              ds_rise_s;

   logic [1:0]        state_r, state_nxt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
   logic              dtack_r, dtack_nxt_s;
   logic              wide_r, wide_nxt_s;
   logic              rw_r, rw_nxt_s;
   logic              prev_ds_r;
   logic [STAT_W-1:0] stall_r;

   ql_slot_counter #(
      .CYC_PER_CHUNK   (CYC_PER_CHUNK),
      .CHUNKS_PER_LINE (CHUNKS_PER_LINE),
      .BUSY_ACTIVE     (BUSY_ACTIVE),
      .BUSY_VBLANK     (BUSY_VBLANK)
   ) u_slot (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .clear     (~enable),
      .ce_bus_p  (ce_bus_p),
      .vblank    (vblank),
      .slot_free (slot_free_s)
   );

   assign grant_s    = grant_f(mode, bus.cpu_rom, slot_free_s);
   assign mode_off_s = mode_is_off(mode);
   assign ds_s       = bus.cpu_uds | bus.cpu_lds;
   assign ds_rise_s  = ds_s & ~prev_ds_r;

   // Next-state logic; strobe abort and timing-off take priority over grants
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      dtack_nxt_s = dtack_r;
      wide_nxt_s  = wide_r;
      rw_nxt_s    = rw_r;
      if ((state_r != ST_IDLE) && (mode_off_s || !ds_s)) begin
         state_nxt_s = ST_IDLE;
         dtack_nxt_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ds_rise_s && !mode_off_s) begin
                  dtack_nxt_s = 1'b1;
                  wide_nxt_s  = bus.cpu_uds & bus.cpu_lds;
                  rw_nxt_s    = bus.cpu_rw;
                  if (bus.cpu_io) begin
                     cnt_nxt_s   = CNT_IO;
                     state_nxt_s = ST_IOWAIT;
                  end else begin
                     state_nxt_s = ST_DECIDE;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            // EXTRA counts down, then behaves like DECIDE: the second byte
            // of a 16-bit access also has to find a free slot.
            ST_DECIDE, ST_EXTRA: begin
               if ((state_r == ST_EXTRA) && (cnt_r != CNT_ONE)) begin
                  cnt_nxt_s = cnt_r - CNT_ONE;
               end else if (grant_s && wide_r) begin
                  cnt_nxt_s   = rw_r ? CNT_RD : CNT_WR;
                  wide_nxt_s  = 1'b0;
                  state_nxt_s = ST_EXTRA;
               end else if (grant_s) begin
                  dtack_nxt_s = 1'b0;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            ST_IOWAIT: begin
               if (cnt_r == CNT_ONE) begin
                  dtack_nxt_s = 1'b0;
                  state_nxt_s = ST_IDLE;
               end else begin
                  cnt_nxt_s = cnt_r - CNT_ONE;
               end
            end
            default: begin
               dtack_nxt_s = 1'b0;
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // FSM, strobe history and DTACK hold-off registers
   always_ff @(posedge clk_sys) begin
      if (reset || !enable) begin
         state_r   <= ST_IDLE;
         cnt_r     <= CNT_ZERO;
         dtack_r   <= 1'b0;
         wide_r    <= 1'b0;
         rw_r      <= 1'b0;
         prev_ds_r <= 1'b0;
      end else if (ce_bus_p) begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         dtack_r   <= dtack_nxt_s;
         wide_r    <= wide_nxt_s;
         rw_r      <= rw_nxt_s;
         prev_ds_r <= ds_s;
      end
   end

   // Saturating stall statistics; survives enable = 0, cleared only by reset
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         stall_r <= {STAT_W{1'b0}};
      end else if (enable && ce_bus_p && dtack_r && (stall_r != STAT_MAX)) begin
         stall_r <= stall_r + STAT_ONE;
      end
   end

   assign bus.ram_delay_dtack = dtack_r;
   assign stall_ticks         = stall_r;

endmodule

// File: tb/tb_ql_bus_timing.sv
module tb_ql_bus_timing;
   import ql_timing_pkg::*;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       enable;
   logic       ce_bus_p;
   logic       vblank;
   logic [1:0] mode;
   logic [7:0] stall_ticks;

   int vectors     = 0;
   int miscompares = 0;
   int tick_idx    = 0;

   ql_bus_timing_if bus ();

   ql_bus_timing #(.STAT_W(8)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .enable      (enable),
      .ce_bus_p    (ce_bus_p),
      .vblank      (vblank),
      .mode        (mode),
      .bus         (bus),
      .stall_ticks (stall_ticks)
   );

   always #5 clk_sys = ~clk_sys;

   // Reference line position: ticks since the timing state was last cleared
   always @(posedge clk_sys) begin
      if (reset || !enable) tick_idx <= 0;
      else if (ce_bus_p)    tick_idx <= tick_idx + 1;
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // Wait until the next edge sees line position pos (chunk*12 + cyc)
   task automatic go_pos(input int pos);
      int steps;
      steps = (pos - (tick_idx % 480) + 480) % 480;
      repeat (steps) step();
   endtask

   task automatic release_bus();
      bus.cpu_uds = 1'b0;
      bus.cpu_lds = 1'b0;
      bus.cpu_rw  = 1'b1;
      bus.cpu_rom = 1'b0;
      bus.cpu_io  = 1'b0;
      step();
   endtask

   // Raise strobes and count ticks with DTACK held off until it drops
   task automatic do_access(input logic u, input logic l, input logic rw,
                            input logic rom, input logic io, input int budget,
                            output int hi, output bit ended);
      bus.cpu_uds = u;
      bus.cpu_lds = l;
      bus.cpu_rw  = rw;
      bus.cpu_rom = rom;
      bus.cpu_io  = io;
      hi    = 0;
      ended = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (bus.ram_delay_dtack === 1'b1) hi++;
         else if (hi > 0) begin
            ended = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; ce_bus_p = 1'b1; vblank = 1'b1; mode = 2'd0;
      bus.cpu_uds = 1'b0; bus.cpu_lds = 1'b0; bus.cpu_rw = 1'b1;
      bus.cpu_rom = 1'b0; bus.cpu_io = 1'b0;
      step(); step();
      vectors++;
      if (bus.ram_delay_dtack !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_dtack: got %b want 0", bus.ram_delay_dtack);
      end
      vectors++;
      if (stall_ticks !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_stall: got %h want 00", stall_ticks);
      end
      reset = 1'b0;
   endtask

   task automatic test_byte_read();
      int hi; bit ended; logic [7:0] s0;
      vblank = 1'b1; mode = 2'd0;
      go_pos(124);
      s0 = stall_ticks;
      do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 40, hi, ended);
      release_bus();
      vectors++;
      if (!ended || hi !== 1) begin
         miscompares++;
         $display("FAIL byte_read: got %0d ticks (ended=%0d) want 1", hi, ended);
      end
      vectors++;
      if (stall_ticks !== s0 + 8'd1) begin
         miscompares++;
         $display("FAIL byte_read_stall: got %h want %h", stall_ticks, s0 + 8'd1);
      end
   endtask

   task automatic test_wide();
      int hi; bit ended; logic [7:0] s0;
      vblank = 1'b1; mode = 2'd0;
      go_pos(124);
      s0 = stall_ticks;
      do_access(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 40, hi, ended);
      release_bus();
      vectors++;
      if (!ended || hi !== 5) begin
         miscompares++;
         $display("FAIL wide_read: got %0d ticks (ended=%0d) want 5", hi, ended);
      end
      vectors++;
      if (stall_ticks !== s0 + 8'd5) begin
         miscompares++;
         $display("FAIL wide_read_stall: got %h want %h", stall_ticks, s0 + 8'd5);
      end
      go_pos(136);
      do_access(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 40, hi, ended);
      release_bus();
      vectors++;
      if (!ended || hi !== 6) begin
         miscompares++;
         $display("FAIL wide_write: got %0d ticks (ended=%0d) want 6", hi, ended);
      end
   endtask

   task automatic test_contention();
      int hi; bit ended; logic [7:0] s0;
      vblank = 1'b0; mode = 2'd0;
      go_pos(63);
      s0 = stall_ticks;
      do_access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 40, hi, ended);
      release_bus();
      vectors++;
      if (!ended || hi !== 9) begin
         miscompares++;
         $display("FAIL contention: got %0d ticks (ended=%0d) want 9", hi, ended);
      end
      vectors++;
      if (stall_ticks !== s0 + 8'd9) begin
         miscompares++;
         $display("FAIL contention_stall: got %h want %h", stall_ticks, s0 + 8'd9);
      end
   endtask

   task automatic test_modes();
      int hi; bit ended; logic [7:0] s0;
      vblank = 1'b0;
      mode = 2'd1;
      go_pos(63);
      do_access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 40, hi, ended);
      release_bus();
      vectors++;
      if (!ended || hi !== 1) begin
         miscompares++;
         $display("FAIL nocont: got %0d ticks (ended=%0d) want 1", hi, ended);
      end
      mode = 2'd0;
      go_pos(63);
      do_access(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 40, hi, ended);
      release_bus();
      vectors++;
      if (!ended || hi !== 1) begin
         miscompares++;
         $display("FAIL rom_bypass: got %0d ticks (ended=%0d) want 1", hi, ended);
      end
      mode = 2'd2;
      go_pos(63);
      s0 = stall_ticks;
      do_access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20, hi, ended);
      release_bus();
      vectors++;
      if (hi !== 0) begin
         miscompares++;
         $display("FAIL mode_off: got %0d ticks want 0", hi);
      end
      vectors++;
      if (stall_ticks !== s0) begin
         miscompares++;
         $display("FAIL mode_off_stall: got %h want %h", stall_ticks, s0);
      end
      mode = 2'd0;
   endtask

   task automatic test_io();
      int hi; bit ended;
      vblank = 1'b0; mode = 2'd0;
      go_pos(63);
      do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 40, hi, ended);
      release_bus();
      vectors++;
      if (!ended || hi !== 3) begin
         miscompares++;
         $display("FAIL io_byte: got %0d ticks (ended=%0d) want 3", hi, ended);
      end
      go_pos(200);
      do_access(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 40, hi, ended);
      release_bus();
      vectors++;
      if (!ended || hi !== 3) begin
         miscompares++;
         $display("FAIL io_wide: got %0d ticks (ended=%0d) want 3", hi, ended);
      end
   endtask

   task automatic test_abort();
      int hi; bit ended;
      vblank = 1'b1; mode = 2'd0;
      go_pos(124);
      bus.cpu_uds = 1'b1; bus.cpu_lds = 1'b1; bus.cpu_rw = 1'b0;
      step(); step();
      vectors++;
      if (bus.ram_delay_dtack !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_pre: got %b want 1", bus.ram_delay_dtack);
      end
      bus.cpu_uds = 1'b0; bus.cpu_lds = 1'b0;
      step();
      vectors++;
      if (bus.ram_delay_dtack !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_clear: got %b want 0", bus.ram_delay_dtack);
      end
      release_bus();
      do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 40, hi, ended);
      release_bus();
      vectors++;
      if (!ended || hi !== 1) begin
         miscompares++;
         $display("FAIL abort_idle: got %0d ticks (ended=%0d) want 1", hi, ended);
      end
   endtask

   task automatic test_back_to_back();
      int hi; bit ended; bit seen;
      vblank = 1'b1; mode = 2'd0;
      go_pos(124);
      do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 40, hi, ended);
      seen = 1'b0;
      repeat (4) begin
         step();
         if (bus.ram_delay_dtack !== 1'b0) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL held_strobe: got retrigger=%b want 0", seen);
      end
      release_bus();
      do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 40, hi, ended);
      release_bus();
      vectors++;
      if (!ended || hi !== 1) begin
         miscompares++;
         $display("FAIL back_to_back: got %0d ticks (ended=%0d) want 1", hi, ended);
      end
   endtask

   task automatic test_wrap();
      int hi; bit ended;
      vblank = 1'b0; mode = 2'd0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (480) step();
      do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 40, hi, ended);
      release_bus();
      vectors++;
      if (!ended || hi !== 12) begin
         miscompares++;
         $display("FAIL wrap: got %0d ticks (ended=%0d) want 12", hi, ended);
      end
   endtask

   task automatic test_saturate();
      int hi; bit ended; logic [8:0] exp;
      vblank = 1'b1; mode = 2'd1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp = 9'd0;
      for (int n = 0; n < 45; n++) begin
         do_access(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 40, hi, ended);
         release_bus();
         exp = exp + 9'd6;
         if (exp > 9'd255) exp = 9'd255;
         vectors++;
         if ({1'b0, stall_ticks} !== exp) begin
            miscompares++;
            $display("FAIL saturate[%0d]: got %h want %h", n, stall_ticks, exp[7:0]);
         end
      end
      mode = 2'd0;
   endtask

   task automatic test_reset_mid_extra();
      vblank = 1'b1; mode = 2'd0;
      go_pos(124);
      bus.cpu_uds = 1'b1; bus.cpu_lds = 1'b1; bus.cpu_rw = 1'b1;
      step(); step(); step();
      reset = 1'b1;
      step();
      vectors++;
      if (bus.ram_delay_dtack !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_extra_dtack: got %b want 0", bus.ram_delay_dtack);
      end
      vectors++;
      if (stall_ticks !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_extra_stall: got %h want 00", stall_ticks);
      end
      bus.cpu_uds = 1'b0; bus.cpu_lds = 1'b0;
      reset = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_byte_read();
      test_wide();
      test_contention();
      test_modes();
      test_io();
      test_abort();
      test_back_to_back();
      test_wrap();
      test_saturate();
      test_reset_mid_extra();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ql_bus_timing.md
Name: ql_bus_timing

Overview:
- Parametrised cycle-level model of ZX8301 bus contention for the QL core.
- Stretches CPU bus cycles, via `ram_delay_dtack`, to approximate original 8-bit-bus RAM, ROM and I/O timing.
- Covers video-fetch slots, refresh slots during vblank, and emulation of two 68008 byte accesses for one 16-bit access.
- Adds selectable contention modes, an I/O wait region, DS-abort handling and a saturating stall counter.
- Sits between the CPU bus decoder and the SDRAM DTACK merge logic.

Parameters:
- CYC_PER_CHUNK, 12, bus ticks per video chunk.
- CHUNKS_PER_LINE, 40, chunks per display line.
- BUSY_ACTIVE, 32, chunks reserved for video fetch outside vblank.
- BUSY_VBLANK, 8, chunks reserved for refresh during vblank.
- RD_EXTRA, 4, extra ticks for the second byte of a 16-bit read.
- WR_EXTRA, 5, extra ticks for the second byte of a 16-bit write.
- IO_WAIT, 3, fixed ticks for an I/O access, slot-independent.
- STAT_W, 16, width of the stall counter.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  0 = hold timing state cleared
- ce_bus_p  in  1  bus tick enable; all state advances only on this
- vblank  in  1  selects BUSY_VBLANK vs BUSY_ACTIVE
- mode  in  2  0 = original, 1 = no slot contention, 2/3 = timing off
- cpu_uds  in  1  upper data strobe
- cpu_lds  in  1  lower data strobe
- cpu_rw  in  1  1 = read
- cpu_rom  in  1  ROM region; bypasses slot check
- cpu_io  in  1  I/O region; uses IO_WAIT
- ram_delay_dtack  out  1  1 = hold off DTACK
- stall_ticks  out  STAT_W  saturating count of ticks with `ram_delay_dtack` = 1

Behaviour:
- Reset, or enable = 0:
  - cyc = 0, chunk = 0, prev_ds = 0, state IDLE, `ram_delay_dtack` = 0.
  - `stall_ticks` clears on reset only; it holds its value while enable = 0.
- Every evaluation below happens on a ce_bus_p tick and uses pre-update cyc/chunk values.
- Counters:
  - cyc increments and wraps at CYC_PER_CHUNK-1.
  - On a cyc wrap, chunk increments and wraps at CHUNKS_PER_LINE-1.
  - Counter widths come from $clog2 of the parameters.
- slot_free = (chunk >= busy) or (cyc == 0), where busy = vblank ? BUSY_VBLANK : BUSY_ACTIVE.
- grant:
  - mode 0: cpu_rom or slot_free.
  - mode 1: always 1.
- ds = uds | lds. A rise is ds & ~prev_ds; prev_ds <= ds every tick.
- FSM, states IDLE, DECIDE, EXTRA, IOWAIT:
  - IDLE:
    - On a rise, if mode >= 2: no action.
    - Else `ram_delay_dtack` <= 1 and latch wide = uds & lds, rw = cpu_rw.
    - If cpu_io: cnt <= IO_WAIT and go to IOWAIT; else go to DECIDE.
  - DECIDE:
    - If grant and wide: cnt <= rw ? RD_EXTRA : WR_EXTRA, wide <= 0, go to EXTRA.
    - If grant and not wide: `ram_delay_dtack` <= 0, go to IDLE.
    - If no grant: stay.
  - EXTRA:
    - If cnt != 1: decrement.
    - If cnt == 1: evaluate exactly as DECIDE. The second byte also waits for a slot.
  - IOWAIT:
    - Decrement cnt.
    - At cnt == 1: `ram_delay_dtack` <= 0, go to IDLE. Wide I/O gets no extra ticks.
- ds falls while not in IDLE (abort): `ram_delay_dtack` <= 0 and go to IDLE on that tick. This overrides grant logic.
- mode switches to >= 2 mid-access: clear `ram_delay_dtack` and go to IDLE on the next tick. Other mode changes apply to the next grant evaluation.
- A new rise is never seen while a strobe stays high. Back-to-back accesses need ds to drop for at least one tick.
- `stall_ticks` increments on each tick where `ram_delay_dtack` = 1, and saturates at all-ones.
- Latency: the minimum stretch is 1 tick (byte access, grant on the first DECIDE tick).

Decomposition:
- Package ql_timing_pkg holds:
  - mode enum: MODE_ORIG, MODE_NOCONT, MODE_OFF.
  - FSM state enum.
  - Default parameter constants.
- One natural sub-module, ql_slot_counter: cyc/chunk counters plus the slot_free output, parametrised by CYC_PER_CHUNK, CHUNKS_PER_LINE, BUSY_ACTIVE and BUSY_VBLANK.

Test Plan:
- Byte read, mode 0, vblank = 1, at chunk 10 -> dtack high for exactly 1 tick.
- 16-bit read, same conditions -> high for 5 ticks; the same as a write -> high for 6 ticks.
- Byte read, vblank = 0, rise at chunk 5 cyc 3 -> grant at tick with cyc = 0 of chunk 6; dtack high 9 ticks.
- Same stimulus, mode 1 -> 1 tick. With cpu_rom = 1 in mode 0 -> 1 tick. With mode 2 -> dtack never asserts and `stall_ticks` is unchanged.
- I/O byte access -> 3 ticks regardless of chunk. ds dropped 2 ticks into a 16-bit write -> dtack clears on that tick and the FSM returns to IDLE.
- Counter wrap: after 480 ticks chunk/cyc return to 0/0. Preset `stall_ticks` near max -> saturates at 0xFFFF. reset mid-EXTRA -> dtack 0 next edge.
